// File: rtl/smux_rr.sv
// Registered N-channel selector with per-channel valid/ready, explicit-select or
// round-robin grant, and a single output register stage.
module smux_rr #(
  parameter int  N_CH  = 4,
  parameter int  W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_en,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready,
  output logic              sel_err
);

  logic              w_load_ok;
  logic              w_sel_ok;
  logic              w_sel_vld;
  logic              w_rr_found;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_grant_vld;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [W-1:0]      w_grant_data;

  logic              r_vld_p1;
  logic [W-1:0]      r_data_p1;
  logic [SEL_W-1:0]  r_ch_p1;
  logic              r_sel_err_p1;
  logic [SEL_W-1:0]  r_ptr;

  // Channel index (base + ofs) mod N_CH; N_CH need not be a power of two.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int ofs);
    logic [31:0] s;
    s = 32'(base) + 32'(ofs);
    return SEL_W'(s % 32'(N_CH));
  endfunction

  assign w_load_ok = ~r_vld_p1 | out_ready;
  assign w_sel_ok  = (32'(sel) < 32'(N_CH));

  always_comb begin
    w_sel_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) w_sel_vld = 1'b1;
    end
  end

  // Round-robin scan starts at the pointer; first valid channel wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!w_rr_found && in_valid[wrap_add(r_ptr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_grant_vld = ~rst & w_load_ok & (rr_en ? w_rr_found : w_sel_vld);
  assign w_grant_idx = rr_en ? w_rr_idx : sel;

  always_comb begin
    in_ready     = '0;
    w_grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = w_grant_vld && (w_grant_idx == SEL_W'(i));
      if (w_grant_idx == SEL_W'(i)) w_grant_data = in_data[i*W +: W];
    end
  end

  // ---- stage p1: output register, rr pointer, select-error flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_data_p1    <= '0;
      r_ch_p1      <= '0;
      r_sel_err_p1 <= 1'b0;
      r_ptr        <= '0;
    end else begin
      r_sel_err_p1 <= ~rr_en & ~w_sel_ok & w_load_ok;
      if (w_grant_vld) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_grant_data;
        r_ch_p1   <= w_grant_idx;
        if (rr_en) r_ptr <= wrap_add(w_grant_idx, 1);
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_ch    = r_ch_p1;
  assign sel_err   = r_sel_err_p1;

endmodule
